// File: rtl/score_matmul.sv
// score_matmul: attention-score stage, S = Q x K^T.
//
// Q rows come from the result SRAM, K rows from the scratchpad SRAM, and each
// S element is written back to the result SRAM as soon as its dot product is
// complete. All arithmetic is DATA_W-bit two's complement with wrap-around.
//
// Ports:
//   clk                          system clock, rising edge
//   reset_n                      asynchronous reset, ACTIVE HIGH (1 = reset)
//   score_valid / score_ready    start handshake (ready = idle)
//   score_done                   one-cycle pulse coincident with the last S write
//   seq_len, head_dim            N (rows of Q and K) and d (columns of Q and K)
//   q_base, k_base, s_base       base addresses of Q, K (scratchpad) and S
//   sram_result_read_*           Q read port, data one cycle after address
//   sram_scratchpad_read_*       K read port, data one cycle after address
//   sram_result_write_*          S write port
//
// Each element takes d+2 cycles: ACC for k = 0..d (d+1 cycles), then one WRITE.
// All outputs are registers; read addresses are loaded one edge ahead so the
// address for index k is on the port during the ACC cycle with counter k.
module score_matmul #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              score_valid,
  output logic              score_ready,
  output logic              score_done,
  input  logic [DIM_W-1:0]  seq_len,
  input  logic [DIM_W-1:0]  head_dim,
  input  logic [ADDR_W-1:0] q_base,
  input  logic [ADDR_W-1:0] k_base,
  input  logic [ADDR_W-1:0] s_base,
  output logic [ADDR_W-1:0] sram_result_read_address,
  input  logic [DATA_W-1:0] sram_result_read_data,
  output logic [ADDR_W-1:0] sram_scratchpad_read_address,
  input  logic [DATA_W-1:0] sram_scratchpad_read_data,
  output logic              sram_result_write_enable,
  output logic [ADDR_W-1:0] sram_result_write_address,
  output logic [DATA_W-1:0] sram_result_write_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [DIM_W-1:0]  ZERO_D = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0]  ONE_D  = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};

  state_t             state_r;
  logic [DIM_W-1:0]   n_r;
  logic [DIM_W-1:0]   d_r;
  logic [ADDR_W-1:0]  k_base_r;
  logic [DIM_W-1:0]   i_r;
  logic [DIM_W-1:0]   j_r;
  logic [DIM_W-1:0]   k_r;
  logic [ADDR_W-1:0]  q_row_r;   // q_base + i*d, kept by a running adder
  logic [ADDR_W-1:0]  k_row_r;   // k_base + j*d, kept by a running adder
  logic [ADDR_W-1:0]  s_addr_r;  // s_base + i*N + j, row-major so just +1 per element
  logic [DATA_W-1:0]  acc_r;
  logic [ADDR_W-1:0]  q_addr_r;
  logic [ADDR_W-1:0]  k_addr_r;
  logic               we_r;
  logic [ADDR_W-1:0]  waddr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               done_r;
  logic               ready_r;

  logic [DATA_W-1:0]  prod_s;
  logic [DATA_W-1:0]  acc_nx_s;
  logic [ADDR_W-1:0]  d_addr_s;
  logic [DIM_W-1:0]   k_inc_s;
  logic               j_last_s;
  logic               i_last_s;
  logic               degenerate_s;
  logic [ADDR_W-1:0]  q_row_nx_s;
  logic [ADDR_W-1:0]  k_row_nx_s;
  logic [DIM_W-1:0]   i_nx_s;
  logic [DIM_W-1:0]   j_nx_s;

  // Datapath helpers: product, accumulator update and next-element row bases.
  always_comb begin
    prod_s       = sram_result_read_data * sram_scratchpad_read_data;
    d_addr_s     = ADDR_W'(d_r);
    k_inc_s      = k_r + ONE_D;
    j_last_s     = (j_r == (n_r - ONE_D));
    i_last_s     = (i_r == (n_r - ONE_D));
    degenerate_s = (seq_len == ZERO_D) || (head_dim == ZERO_D);
    q_row_nx_s   = q_row_r;
    k_row_nx_s   = k_row_r;
    i_nx_s       = i_r;
    j_nx_s       = j_r;
    // k = 1 starts a fresh dot product; later indices add onto it.
    if (k_r == ONE_D) begin
      acc_nx_s = prod_s;
    end else begin
      acc_nx_s = acc_r + prod_s;
    end
    // On j wrap the next Q row starts and K restarts from row 0.
    if (j_last_s) begin
      j_nx_s     = ZERO_D;
      i_nx_s     = i_r + ONE_D;
      q_row_nx_s = q_row_r + d_addr_s;
      k_row_nx_s = k_base_r;
    end else begin
      j_nx_s     = j_r + ONE_D;
      i_nx_s     = i_r;
      q_row_nx_s = q_row_r;
      k_row_nx_s = k_row_r + d_addr_s;
    end
  end

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_r  <= IDLE;
      n_r      <= ZERO_D;
      d_r      <= ZERO_D;
      k_base_r <= ZERO_A;
      i_r      <= ZERO_D;
      j_r      <= ZERO_D;
      k_r      <= ZERO_D;
      q_row_r  <= ZERO_A;
      k_row_r  <= ZERO_A;
      s_addr_r <= ZERO_A;
      acc_r    <= ZERO_W;
      q_addr_r <= ZERO_A;
      k_addr_r <= ZERO_A;
      we_r     <= 1'b0;
      waddr_r  <= ZERO_A;
      wdata_r  <= ZERO_W;
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          we_r   <= 1'b0;
          done_r <= 1'b0;
          // Empty matrices are accepted but produce nothing: remain idle.
          if (ready_r && score_valid && !degenerate_s) begin
            n_r      <= seq_len;
            d_r      <= head_dim;
            k_base_r <= k_base;
            i_r      <= ZERO_D;
            j_r      <= ZERO_D;
            k_r      <= ZERO_D;
            q_row_r  <= q_base;
            k_row_r  <= k_base;
            s_addr_r <= s_base;
            q_addr_r <= q_base;
            k_addr_r <= k_base;
            ready_r  <= 1'b0;
            state_r  <= ACC;
          end else begin
            ready_r  <= 1'b1;
          end
        end

        ACC: begin
          if (k_r == d_r) begin
            // Last product folds in here and goes straight to the write port.
            acc_r   <= acc_nx_s;
            wdata_r <= acc_nx_s;
            waddr_r <= s_addr_r;
            we_r    <= 1'b1;
            done_r  <= i_last_s && j_last_s;
            state_r <= WRITE;
          end else begin
            if (k_r != ZERO_D) begin
              acc_r <= acc_nx_s;
            end else begin
              acc_r <= acc_r;
            end
            // Present the address of index k+1 for the next cycle, if any.
            if (k_inc_s < d_r) begin
              q_addr_r <= q_addr_r + ONE_A;
              k_addr_r <= k_addr_r + ONE_A;
            end else begin
              q_addr_r <= q_addr_r;
              k_addr_r <= k_addr_r;
            end
            k_r <= k_inc_s;
          end
        end

        WRITE: begin
          we_r     <= 1'b0;
          done_r   <= 1'b0;
          k_r      <= ZERO_D;
          s_addr_r <= s_addr_r + ONE_A;
          if (done_r) begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end else begin
            i_r      <= i_nx_s;
            j_r      <= j_nx_s;
            q_row_r  <= q_row_nx_s;
            k_row_r  <= k_row_nx_s;
            q_addr_r <= q_row_nx_s;
            k_addr_r <= k_row_nx_s;
            state_r  <= ACC;
          end
        end

        default: begin
          we_r    <= 1'b0;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign score_ready                  = ready_r;
  assign score_done                   = done_r;
  assign sram_result_read_address     = q_addr_r;
  assign sram_scratchpad_read_address = k_addr_r;
  assign sram_result_write_enable     = we_r;
  assign sram_result_write_address    = waddr_r;
  assign sram_result_write_data       = wdata_r;

endmodule

// File: tb/tb_score_matmul.sv
// Scoreboard bench for score_matmul: directed matrices with hand-computed S.
// Stimulus pushes expected writes and done cycles; a negedge monitor pops them.
module tb_score_matmul;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        score_valid = 1'b0;
  logic        score_ready;
  logic        score_done;
  logic [15:0] seq_len = 16'd0;
  logic [15:0] head_dim = 16'd0;
  logic [15:0] q_base = 16'd0;
  logic [15:0] k_base = 16'd0;
  logic [15:0] s_base = 16'd0;
  logic [15:0] sram_result_read_address;
  logic [31:0] sram_result_read_data = 32'd0;
  logic [15:0] sram_scratchpad_read_address;
  logic [31:0] sram_scratchpad_read_data = 32'd0;
  logic        sram_result_write_enable;
  logic [15:0] sram_result_write_address;
  logic [31:0] sram_result_write_data;

  score_matmul dut (
    .clk                          (clk),
    .reset_n                      (reset_n),
    .score_valid                  (score_valid),
    .score_ready                  (score_ready),
    .score_done                   (score_done),
    .seq_len                      (seq_len),
    .head_dim                     (head_dim),
    .q_base                       (q_base),
    .k_base                       (k_base),
    .s_base                       (s_base),
    .sram_result_read_address     (sram_result_read_address),
    .sram_result_read_data        (sram_result_read_data),
    .sram_scratchpad_read_address (sram_scratchpad_read_address),
    .sram_scratchpad_read_data    (sram_scratchpad_read_data),
    .sram_result_write_enable     (sram_result_write_enable),
    .sram_result_write_address    (sram_result_write_address),
    .sram_result_write_data       (sram_result_write_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          exp_done_q[$];
  logic [31:0] rmem [0:255];
  logic [31:0] smem [0:255];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          write_cnt = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  bit          ready_pending = 1'b0;
  wr_t         mon_e;
  int          mon_dc;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // SRAM models: one-cycle read latency, synchronous write.
  always @(posedge clk) begin
    sram_result_read_data     <= rmem[sram_result_read_address[7:0]];
    sram_scratchpad_read_data <= smem[sram_scratchpad_read_address[7:0]];
    if (sram_result_write_enable) rmem[sram_result_write_address[7:0]] <= sram_result_write_data;
    cyc <= cyc + 1;
  end

  // Monitor: compare writes and done pulses against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      if (ready_pending) begin
        check("ready_after_done", {63'd0, score_ready}, 64'd1);
        ready_pending = 1'b0;
      end
      if (!score_ready) busy_cnt++;
      if (sram_result_write_enable) begin
        write_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                   sram_result_write_address, sram_result_write_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("s_write", {16'd0, sram_result_write_address, sram_result_write_data},
                {16'd0, mon_e});
        end
      end
      if (score_done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
        end else begin
          mon_dc = exp_done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_dc));
          check("write_with_done", {63'd0, sram_result_write_enable}, 64'd1);
          ready_pending = 1'b1;
        end
      end
    end
  end

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.a = a[15:0];
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_test1();
    push_wr(20, 32'd17);
    push_wr(21, 32'd23);
    push_wr(22, 32'd39);
    push_wr(23, 32'd53);
  endtask

  task automatic start(input int n, input int d, input int qb, input int kb, input int sb,
                       input bit busy);
    @(negedge clk);
    seq_len     = n[15:0];
    head_dim    = d[15:0];
    q_base      = qb[15:0];
    k_base      = kb[15:0];
    s_base      = sb[15:0];
    score_valid = 1'b1;
    if (busy) exp_done_q.push_back(cyc + n * n * (d + 2));
    @(negedge clk);
    score_valid = 1'b0;
    if (busy) check("ready_drop", {63'd0, score_ready}, 64'd0);
  endtask

  task automatic wait_done();
    int target;
    int t;
    target = done_cnt + 1;
    t = 0;
    while (done_cnt < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {63'd0, (done_cnt >= target)}, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic degenerate(input int n, input int d);
    int b0;
    int w0;
    int d0;
    b0 = busy_cnt;
    w0 = write_cnt;
    d0 = done_cnt;
    start(n, d, 10, 0, 100, 1'b0);
    repeat (20) @(negedge clk);
    check("degen_ready_drop", 64'(busy_cnt - b0), 64'd0);
    check("degen_writes", 64'(write_cnt - w0), 64'd0);
    check("degen_done", 64'(done_cnt - d0), 64'd0);
  endtask

  initial begin
    int w0;
    int t;
    for (int a = 0; a < 256; a++) begin
      rmem[a] = 32'd0;
      smem[a] = 32'd0;
    end
    rmem[10] = 32'd1; rmem[11] = 32'd2; rmem[12] = 32'd3; rmem[13] = 32'd4;
    smem[0]  = 32'd5; smem[1]  = 32'd6; smem[2]  = 32'd7; smem[3]  = 32'd8;
    rmem[40] = 32'hFFFF_FFFD;
    smem[10] = 32'd4;
    rmem[60] = 32'h7FFF_FFFF; rmem[61] = 32'd1;
    smem[20] = 32'd2;         smem[21] = 32'd1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, score_ready}, 64'd1);
    check("rst_done", {63'd0, score_done}, 64'd0);
    check("rst_we", {63'd0, sram_result_write_enable}, 64'd0);
    check("rst_raddr", {32'd0, sram_result_read_address, sram_scratchpad_read_address}, 64'd0);
    check("rst_wport", {16'd0, sram_result_write_address, sram_result_write_data}, 64'd0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);

    // 2x2 basic.
    push_test1();
    start(2, 2, 10, 0, 20, 1'b1);
    wait_done();

    // Signed 1x1.
    push_wr(50, 32'hFFFF_FFF4);
    start(1, 1, 40, 10, 50, 1'b1);
    wait_done();

    // Wrap-around accumulation.
    push_wr(70, 32'hFFFF_FFFF);
    start(1, 2, 60, 20, 70, 1'b1);
    wait_done();

    // Degenerate dimensions.
    degenerate(3, 0);
    degenerate(0, 4);

    // Start request while busy, with different configuration on the inputs.
    push_test1();
    start(2, 2, 10, 0, 20, 1'b1);
    repeat (5) @(negedge clk);
    seq_len = 16'd3; head_dim = 16'd1; q_base = 16'd40; k_base = 16'd10; s_base = 16'd90;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    wait_done();

    // Reset during the third element, then a fresh full run.
    w0 = write_cnt;
    push_test1();
    start(2, 2, 10, 0, 20, 1'b1);
    t = 0;
    while (write_cnt < w0 + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("writes_before_reset", 64'(write_cnt - w0), 64'd2);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midrst_we", {63'd0, sram_result_write_enable}, 64'd0);
    check("midrst_ready", {63'd0, score_ready}, 64'd1);
    check("midrst_raddr", {32'd0, sram_result_read_address, sram_scratchpad_read_address}, 64'd0);
    check("midrst_wport", {16'd0, sram_result_write_address, sram_result_write_data}, 64'd0);
    exp_q.delete();
    exp_done_q.delete();
    ready_pending = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    push_test1();
    start(2, 2, 10, 0, 20, 1'b1);
    wait_done();

    check("queue_drained", 64'(exp_q.size() + exp_done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
